// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: 8259A priority resolver, In-Service Register owner
// and 8086-mode two-pulse INTA sequencer, including OCW2 EOI/rotation commands.
module interrupt_ack_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] risedBits,
  input  logic [4:0] icw2Base,
  input  logic       aeoi,
  input  logic       eoiValid,
  input  logic [2:0] eoiCmd,
  input  logic [2:0] eoiLevel,
  input  logic       intaN,
  input  logic       readPriorityAck,
  output logic       intOut,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic [7:0] vectorOut,
  output logic       vectorOe,
  output logic [7:0] isr
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    WAIT2,
    ACK2
  } seqState;

  localparam logic [2:0] CMD_NS_EOI     = 3'b001;
  localparam logic [2:0] CMD_SP_EOI     = 3'b011;
  localparam logic [2:0] CMD_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] CMD_ROT_SP_EOI = 3'b111;
  localparam logic [2:0] CMD_SET_PRI    = 3'b110;

  seqState    state;
  logic [2:0] lowestPri;
  logic       lastAck;
  logic       ackPending;
  logic       prevInta;
  logic [2:0] lvl;
  logic       spurious;
  logic       isrSetDone;   // ACK1 already set the ISR bit and is stalled on the handshake

  logic [3:0] candTop;      // {found, level} of the best pending request
  logic [3:0] isrTop;       // {found, level} of the best in-service level
  logic       candValid;
  logic       intaFall;
  logic [7:0] eoiClr;
  logic [7:0] ackSet;
  logic [7:0] aeoiClr;
  logic [2:0] lowestPriNext;

  // Highest-priority set bit of vec; priority starts just above `lowest` and wraps.
  function automatic logic [3:0] topLevel(input logic [7:0] vec, input logic [2:0] lowest);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    // Walk from lowest to highest priority so the highest set bit is written last.
    for (int i = 7; i >= 0; i--) begin
      idx = lowest + 3'(i + 1);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Position in the current rotation, 0 = highest priority.
  function automatic logic [2:0] rankOf(input logic [2:0] level, input logic [2:0] lowest);
    return level - lowest - 3'd1;
  endfunction

  assign intaFall = !intaN && prevInta;

  // Priority resolution against the ISR (fully nested), using pre-EOI state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    candTop   = topLevel(risedBits & ~isr, lowestPri);
    isrTop    = topLevel(isr, lowestPri);
    candValid = candTop[3] &&
                (!isrTop[3] || (rankOf(candTop[2:0], lowestPri) < rankOf(isrTop[2:0], lowestPri)));
  end

  // OCW2 decode: which ISR bit to clear and the new rotation point.
  always_comb begin
    eoiClr        = 8'b0;
    lowestPriNext = lowestPri;
    if (eoiValid) begin
      case (eoiCmd)
        CMD_NS_EOI:     if (isrTop[3]) eoiClr = 8'b1 << isrTop[2:0];
        CMD_SP_EOI:     eoiClr = 8'b1 << eoiLevel;
        CMD_ROT_NS_EOI: if (isrTop[3]) begin
                          eoiClr        = 8'b1 << isrTop[2:0];
                          lowestPriNext = isrTop[2:0];
                        end
        CMD_ROT_SP_EOI: begin
                          eoiClr        = 8'b1 << eoiLevel;
                          lowestPriNext = eoiLevel;
                        end
        CMD_SET_PRI:    lowestPriNext = eoiLevel;
        default:        ;
      endcase
    end
  end

  // ISR set on first acknowledge and auto-EOI clear at the end of the second pulse.
  always_comb begin
    ackSet  = 8'b0;
    aeoiClr = 8'b0;
    if (state == ACK1 && !isrSetDone && candValid) ackSet = 8'b1 << candTop[2:0];
    if (state == ACK2 && intaN && aeoi && !spurious) aeoiClr = 8'b1 << lvl;
  end

  // Sequencer FSM, ISR, rotation pointer, IRR handshake and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state        <= IDLE;
      lowestPri    <= 3'd7;
      lastAck      <= 1'b0;
      ackPending   <= 1'b0;
      prevInta     <= 1'b1;
      lvl          <= 3'd0;
      spurious     <= 1'b0;
      isrSetDone   <= 1'b0;
      intOut       <= 1'b0;
      readPriority <= 1'b0;
      resetIRR     <= 3'd0;
      vectorOut    <= 8'd0;
      vectorOe     <= 1'b0;
      isr          <= 8'd0;
    end else begin
      prevInta     <= intaN;
      readPriority <= 1'b0;
      lowestPri    <= lowestPriNext;
      // EOI clear first, then the acknowledge set wins on the same bit.
      isr          <= (isr & ~eoiClr & ~aeoiClr) | ackSet;

      if (readPriorityAck != lastAck) begin
        ackPending <= 1'b0;
        lastAck    <= readPriorityAck;
      end

      case (state)
        IDLE: if (candValid) state <= REQ;

        REQ: begin
          intOut <= 1'b1;
          if (intaFall) state <= ACK1;
        end

        ACK1: begin
          intOut <= 1'b0;
          if (isrSetDone) begin
            if (!ackPending) begin
              readPriority <= 1'b1;
              resetIRR     <= lvl;
              ackPending   <= 1'b1;
              isrSetDone   <= 1'b0;
              state        <= WAIT2;
            end
          end else if (candValid) begin
            lvl      <= candTop[2:0];
            spurious <= 1'b0;
            if (!ackPending) begin
              readPriority <= 1'b1;
              resetIRR     <= candTop[2:0];
              ackPending   <= 1'b1;
              state        <= WAIT2;
            end else begin
              isrSetDone <= 1'b1;
            end
          end else begin
            lvl      <= 3'd7;
            spurious <= 1'b1;
            state    <= WAIT2;
          end
        end

        WAIT2: if (intaFall) begin
          vectorOut <= {icw2Base, lvl};
          vectorOe  <= 1'b1;
          state     <= ACK2;
        end

        ACK2: if (intaN) begin
          vectorOe <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// tb_interrupt_ack_sequencer: transaction-level reference model of the 8259A
// acknowledge path, driven with directed scenarios and randomized traffic.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] risedBits;
  logic [4:0] icw2Base;
  logic       aeoi;
  logic       eoiValid;
  logic [2:0] eoiCmd;
  logic [2:0] eoiLevel;
  logic       intaN;
  logic       readPriorityAck;
  logic       intOut;
  logic       readPriority;
  logic [2:0] resetIRR;
  logic [7:0] vectorOut;
  logic       vectorOe;
  logic [7:0] isr;

  always #5 clk = ~clk;

  interrupt_ack_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .risedBits       (risedBits),
    .icw2Base        (icw2Base),
    .aeoi            (aeoi),
    .eoiValid        (eoiValid),
    .eoiCmd          (eoiCmd),
    .eoiLevel        (eoiLevel),
    .intaN           (intaN),
    .readPriorityAck (readPriorityAck),
    .intOut          (intOut),
    .readPriority    (readPriority),
    .resetIRR        (resetIRR),
    .vectorOut       (vectorOut),
    .vectorOe        (vectorOe),
    .isr             (isr)
  );

  int checks = 0;
  int passes = 0;

  // Reference state: in-service bits, rotation point, outstanding IRR clear.
  logic [7:0] mIsr;
  int         mLp;
  bit         mAckOwed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Highest-priority set level: (lp+1)%8 first, then upward with wrap; -1 if none.
  function automatic int topOf(input logic [7:0] vec, input int lp);
    for (int i = 1; i <= 8; i++) if (vec[(lp + i) % 8]) return (lp + i) % 8;
    return -1;
  endfunction

  function automatic int rankOf(input int l, input int lp);
    return (l - lp + 7) % 8;
  endfunction

  // Level that would be granted, or -1 if nothing beats the in-service level.
  function automatic int candOf(input logic [7:0] req, input logic [7:0] inSvc, input int lp);
    int c;
    int t;
    c = topOf(req & ~inSvc, lp);
    if (c < 0) return -1;
    t = topOf(inSvc, lp);
    if (t >= 0 && rankOf(c, lp) >= rankOf(t, lp)) return -1;
    return c;
  endfunction

  task automatic doEoi(input logic [2:0] cmd, input logic [2:0] level);
    int t;
    eoiValid = 1'b1;
    eoiCmd   = cmd;
    eoiLevel = level;
    tick();
    eoiValid = 1'b0;
    t = topOf(mIsr, mLp);
    case (cmd)
      3'b001: if (t >= 0) mIsr[t] = 1'b0;
      3'b011: mIsr[level] = 1'b0;
      3'b101: if (t >= 0) begin mIsr[t] = 1'b0; mLp = t; end
      3'b111: begin mIsr[level] = 1'b0; mLp = int'(level); end
      3'b110: mLp = int'(level);
      default: ;
    endcase
    check("eoi_isr", isr, mIsr);
  endtask

  // One full request/acknowledge transaction; the bench plays IRR and CPU.
  task automatic doAck(input logic [7:0] req, input bit withdraw, input bit holdAck);
    int         exp;
    int         lvlExp;
    logic [2:0] lb;
    logic [7:0] expVec;
    exp = candOf(req, mIsr, mLp);
    risedBits = req;
    if (exp < 0) begin
      repeat (4) begin
        tick();
        check("no_int", intOut, 0);
      end
      risedBits = 8'h00;
      tick();
      return;
    end
    tick();
    check("int_lat1", intOut, 0);
    tick();
    check("int_lat2", intOut, 1);
    if (withdraw) risedBits = 8'h00;
    lvlExp = withdraw ? -1 : exp;

    intaN = 1'b0;
    tick();
    tick();
    if (lvlExp < 0) begin
      check("spur_rp", readPriority, 0);
      check("spur_isr", isr, mIsr);
    end else begin
      mIsr[lvlExp] = 1'b1;
      check("ack1_isr", isr, mIsr);
      if (mAckOwed) begin
        repeat (3) begin
          check("stall_rp", readPriority, 0);
          check("stall_isr", isr, mIsr);
          tick();
        end
        readPriorityAck = ~readPriorityAck;
        mAckOwed = 1'b0;
        tick();
        check("stall_rp_wait", readPriority, 0);
        tick();
      end
      check("rp_pulse", readPriority, 1);
      check("reset_irr", resetIRR, lvlExp);
      risedBits[lvlExp] = 1'b0;
      if (holdAck) mAckOwed = 1'b1;
      else readPriorityAck = ~readPriorityAck;
    end

    intaN = 1'b1;
    tick();
    if (lvlExp >= 0) check("rp_one_cycle", readPriority, 0);
    check("int_dropped", intOut, 0);

    intaN = 1'b0;
    tick();
    lb     = (lvlExp < 0) ? 3'd7 : 3'(lvlExp);
    expVec = {icw2Base, lb};
    check("vec_oe", vectorOe, 1);
    check("vec", vectorOut, expVec);
    tick();
    check("vec_oe_hold", vectorOe, 1);
    intaN = 1'b1;
    tick();
    check("vec_oe_off", vectorOe, 0);
    if (aeoi && lvlExp >= 0) mIsr[lvlExp] = 1'b0;
    check("ack2_isr", isr, mIsr);
    risedBits = 8'h00;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] cmd;
    bit         wd;

    rst_n = 1'b0; risedBits = 8'h00; icw2Base = 5'h10; aeoi = 1'b0;
    eoiValid = 1'b0; eoiCmd = 3'd0; eoiLevel = 3'd0; intaN = 1'b1; readPriorityAck = 1'b0;
    mIsr = 8'h00; mLp = 7; mAckOwed = 1'b0;
    tick();
    tick();
    check("rst_int", intOut, 0);
    check("rst_rp", readPriority, 0);
    check("rst_irr", resetIRR, 0);
    check("rst_vec", vectorOut, 0);
    check("rst_oe", vectorOe, 0);
    check("rst_isr", isr, 0);
    rst_n = 1'b1;
    tick();

    // Single request: IR3, vector 0x83.
    doAck(8'h08, 1'b0, 1'b0);

    // Nesting: IR1 preempts IR3, IR5 waits until both are cleared.
    doAck(8'h22, 1'b0, 1'b0);
    doAck(8'h20, 1'b0, 1'b0);
    doEoi(3'b011, 3'd1);
    doEoi(3'b011, 3'd3);
    doAck(8'h20, 1'b0, 1'b0);
    doEoi(3'b011, 3'd5);

    // Rotation.
    doEoi(3'b110, 3'd4);
    doAck(8'hFF, 1'b0, 1'b0);
    doEoi(3'b101, 3'd0);
    doAck(8'hFF, 1'b0, 1'b0);
    doEoi(3'b001, 3'd0);

    // Spurious.
    doAck(8'h01, 1'b1, 1'b0);

    // Auto-EOI with the IRR handshake stalled.
    aeoi = 1'b1;
    doAck(8'h04, 1'b0, 1'b1);
    doAck(8'h40, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        cmd = 3'($urandom_range(0, 7));
        if (mIsr == 8'h00 && cmd == 3'b111) cmd = 3'b011;
        if (mIsr == 8'h00 && cmd == 3'b101) cmd = 3'b001;
        doEoi(cmd, 3'($urandom_range(0, 7)));
      end else begin
        aeoi     = 1'($urandom_range(0, 1));
        icw2Base = 5'($urandom_range(0, 31));
        wd       = ($urandom_range(0, 7) == 0);
        doAck(8'($urandom_range(1, 255)), wd, 1'b0);
      end
    end

    // Reset in the middle of the second acknowledge.
    while (mIsr != 8'h00) doEoi(3'b001, 3'd0);
    aeoi = 1'b0;
    doEoi(3'b110, 3'd2);
    risedBits = 8'h10;
    tick();
    tick();
    check("mid_int", intOut, 1);
    intaN = 1'b0;
    tick();
    tick();
    check("mid_rp", readPriority, 1);
    check("mid_irr", resetIRR, 4);
    risedBits = 8'h00;
    readPriorityAck = ~readPriorityAck;
    intaN = 1'b1;
    tick();
    intaN = 1'b0;
    tick();
    check("mid_oe", vectorOe, 1);
    rst_n = 1'b0;
    intaN = 1'b1;
    readPriorityAck = 1'b0;
    tick();
    check("abort_int", intOut, 0);
    check("abort_rp", readPriority, 0);
    check("abort_irr", resetIRR, 0);
    check("abort_vec", vectorOut, 0);
    check("abort_oe", vectorOe, 0);
    check("abort_isr", isr, 0);
    rst_n = 1'b1;
    mIsr = 8'h00; mLp = 7; mAckOwed = 1'b0;
    tick();
    // IR0 must win again, showing the rotation point returned to 7.
    doAck(8'hFF, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Consumer end of the interrupt request path in the 8259A PIC. Takes the already-masked pending requests from the Interrupt Request Register, resolves priority against the In-Service Register (ISR) it owns, raises INT to the CPU, and runs the two-pulse 8086-mode INTA sequence. On acknowledge it tells the IRR which level to clear through the readPriority/resetIRR/readPriorityAck handshake. It also executes OCW2 end-of-interrupt and rotation commands.

## Interface
- No parameters. Fixed at 8 IR levels and 8086-mode vectors.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- risedBits  in  8  valid pending requests from IRR, bit n = IRn
- icw2Base  in  5  vector bits T7..T3 from ICW2
- aeoi  in  1  auto-EOI mode (ICW4 bit 1)
- eoiValid  in  1  one-cycle strobe: OCW2 command present
- eoiCmd  in  3  OCW2 {R, SL, EOI}
- eoiLevel  in  3  OCW2 L2..L0
- intaN  in  1  CPU interrupt acknowledge, active low, synchronous to clk
- readPriorityAck  in  1  toggles once per IRR clear; reset value 0
- intOut  out  1  INT to CPU
- readPriority  out  1  one-cycle pulse requesting IRR clear
- resetIRR  out  3  level for the IRR to clear; stable until ack
- vectorOut  out  8  interrupt vector
- vectorOe  out  1  vectorOut valid on the data bus
- isr  out  8  in-service register

## Operation
- Internal state: lowestPri (3b, reset 7, so IR0 is highest), lastAck (reset 0), ackPending, prevInta (reset 1), latched level `lvl`.
- Priority order: (lowestPri+1) mod 8 is highest, then increments with wrap.
- Candidate: the highest-priority bit of risedBits & ~isr that is strictly higher than the highest-priority set ISR bit (fully nested).
- FSM:
  - IDLE: a candidate exists -> REQ.
  - REQ: intOut=1. A falling edge on intaN (intaN=0, prevInta=1) -> ACK1. If the candidate disappears before the edge, stay in REQ with intOut held.
  - ACK1 (single cycle):
    - Candidate exists: lvl := candidate, isr[lvl] := 1, readPriority := 1, resetIRR := lvl, ackPending := 1.
    - No candidate: lvl := 7, spurious, ISR unchanged, no handshake.
    - Then -> WAIT2. intOut := 0.
  - WAIT2: falling edge on intaN -> ACK2.
  - ACK2: vectorOut = {icw2Base, lvl}, vectorOe=1 while intaN=0. When intaN rises: vectorOe := 0; if aeoi and not spurious, isr[lvl] := 0; -> IDLE.
- Handshake: ackPending clears in the cycle readPriorityAck != lastAck, and lastAck := readPriorityAck in that cycle. ACK1 never issues a new readPriority while ackPending=1; it waits in ACK1, holding the ISR set already performed.
- OCW2 commands, accepted in any state on eoiValid:
  - 001: non-specific EOI, clear the highest-priority ISR bit.
  - 011: specific EOI, clear isr[eoiLevel].
  - 101: rotate on non-specific EOI, clear the highest-priority ISR bit b and set lowestPri := b.
  - 111: clear isr[eoiLevel] and set lowestPri := eoiLevel.
  - 110: set lowestPri := eoiLevel.
  - 000, 010, 100: no-op.
  - EOI with an empty ISR is a no-op.
- Simultaneous OCW2 and ACK1 ISR set in the same cycle: the EOI clear is applied first, then the set. The candidate uses pre-EOI state.

## Timing
- Reset values: intOut 0, readPriority 0, resetIRR 0, vectorOut 0, vectorOe 0, isr 0. The FSM goes to IDLE.
- rst_n low mid-sequence aborts immediately; the next cycle shows the reset values.
- INT latency: a request visible at edge k gives intOut=1 after edge k+1 (IDLE->REQ), plus one more edge for registered intOut, so 2 cycles.
- ISR bit set and readPriority high appear after the edge following the ACK1 cycle. readPriority is high for exactly 1 cycle.
- vectorOe and vectorOut are registered: valid from 1 cycle after the second falling edge, deasserted 1 cycle after intaN returns high.
- An INTA falling edge in IDLE or in ACK1 is ignored.
- intaN must stay low at least 2 cycles per pulse.

## Test plan
- **Single request:** risedBits=0x08, icw2Base=0x10.
  - intOut rises after 2 cycles.
  - First INTA: isr=0x08, readPriority pulse with resetIRR=3.
  - Second INTA: vectorOut=0x83. Then intOut=0.
- **Nesting:** with isr=0x08, risedBits=0x22.
  - IR1 wins and intOut rises; IR5 gets no INT.
  - After 011/level1 and 011/level3, IR5 is serviced.
- **Rotation:** issue 110 with level 4, then risedBits=0xFF.
  - Acknowledge gives level 5 (vector low bits 5).
  - 101 clears bit 5, and lowestPri becomes 5.
- **Spurious:** request 0x01 withdrawn before the first INTA.
  - Vector = {base,3'b111}, isr unchanged, no readPriority pulse.
- **AEOI plus handshake stall:** aeoi=1, readPriorityAck held constant.
  - The second request waits in ACK1.
  - After ack toggles, it proceeds; isr returns to 0 at the second intaN rise.
- **Reset mid-ACK2:** rst_n=0 while vectorOe=1.
  - Next cycle all outputs are 0 and lowestPri=7.
